// File: rtl/axi_sram_responder.sv
// AXI4 responder serving one write and one read burst at a time from a byte-strobed register array.
// Optional: define AXI_SRAM_RESP_DECERR_EN to answer DECERR for beats beyond MEM_WORDS instead of wrapping.
module axi_sram_responder #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 11,
  parameter int unsigned MEM_WORDS      = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AXI_ID_WIDTH-1:0]       slv_aw_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     slv_aw_awaddr,
  input  logic [7:0]                    slv_aw_awlen,
  input  logic [2:0]                    slv_aw_awsize,
  input  logic [1:0]                    slv_aw_awburst,
  input  logic                          slv_aw_awvalid,
  output logic                          slv_aw_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     slv_w_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   slv_w_wstrb,
  input  logic                          slv_w_wlast,
  input  logic                          slv_w_wvalid,
  output logic                          slv_w_wready,
  output logic [AXI_ID_WIDTH-1:0]       slv_b_bid,
  output logic [1:0]                    slv_b_bresp,
  output logic                          slv_b_bvalid,
  input  logic                          slv_b_bready,
  input  logic [AXI_ID_WIDTH-1:0]       slv_ar_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     slv_ar_araddr,
  input  logic [7:0]                    slv_ar_arlen,
  input  logic [2:0]                    slv_ar_arsize,
  input  logic [1:0]                    slv_ar_arburst,
  input  logic                          slv_ar_arvalid,
  output logic                          slv_ar_arready,
  output logic [AXI_ID_WIDTH-1:0]       slv_r_rid,
  output logic [AXI_DATA_WIDTH-1:0]     slv_r_rdata,
  output logic [1:0]                    slv_r_rresp,
  output logic                          slv_r_rlast,
  output logic                          slv_r_rvalid,
  input  logic                          slv_r_rready
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam logic [2:0]  MAX_SIZE = 3'(OFFS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
    logic [AXI_ADDR_WIDTH-1:0] step;
    step = AXI_ADDR_WIDTH'(1) << size;
    if (burst == BURST_FIXED) next_addr = addr;
    else                      next_addr = (addr & ~(step - AXI_ADDR_WIDTH'(1))) + step;
  endfunction

  function automatic logic [1:0] beat_resp(input logic oob, input logic [2:0] size,
                                           input logic [1:0] burst);
    beat_resp = RESP_OKAY;
    if (size > MAX_SIZE || (burst != BURST_FIXED && burst != BURST_INCR)) beat_resp = RESP_SLVERR;
    if (oob) beat_resp = RESP_DECERR;
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    resp_max = (a > b) ? a : b;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic                      r_rdy_en;

  // ---------------- write path ----------------
  logic [1:0]                r_wr_state;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  logic [AXI_ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]                r_wr_len;
  logic [2:0]                r_wr_size;
  logic [1:0]                r_wr_burst;
  logic [8:0]                r_wr_cnt;
  logic [1:0]                r_wr_err;
  logic [1:0]                r_bresp;

  logic                      w_aw_hs, w_w_hs, w_wr_oob, w_wr_mem_en;
  logic [IDX_W-1:0]          w_wr_idx;
  logic [1:0]                w_wr_beat_resp, w_wr_len_resp;
  logic [8:0]                w_wr_cnt_next;

  assign slv_aw_awready = (r_wr_state == W_IDLE) && r_rdy_en;
  assign slv_w_wready   = (r_wr_state == W_DATA);
  assign slv_b_bvalid   = (r_wr_state == W_RESP);
  assign slv_b_bid      = r_bid;
  assign slv_b_bresp    = r_bresp;

  assign w_aw_hs        = slv_aw_awvalid && slv_aw_awready;
  assign w_w_hs         = slv_w_wvalid && slv_w_wready;
  assign w_wr_idx       = r_wr_addr[OFFS +: IDX_W];
  assign w_wr_beat_resp = beat_resp(w_wr_oob, r_wr_size, r_wr_burst);
  assign w_wr_cnt_next  = r_wr_cnt + 9'd1;
  assign w_wr_len_resp  = (w_wr_cnt_next == {1'b0, r_wr_len} + 9'd1) ? RESP_OKAY : RESP_SLVERR;
  assign w_wr_mem_en    = w_w_hs && !rst_i && (w_wr_beat_resp == RESP_OKAY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_rdy_en   <= 1'b0;
      r_bid      <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_cnt   <= '0;
      r_wr_err   <= RESP_OKAY;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_wr_state)
        W_IDLE: if (w_aw_hs) begin
          r_bid      <= slv_aw_awid;
          r_wr_addr  <= slv_aw_awaddr;
          r_wr_len   <= slv_aw_awlen;
          r_wr_size  <= slv_aw_awsize;
          r_wr_burst <= slv_aw_awburst;
          r_wr_cnt   <= '0;
          r_wr_err   <= RESP_OKAY;
          r_wr_state <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          r_wr_addr <= next_addr(r_wr_addr, r_wr_size, r_wr_burst);
          r_wr_cnt  <= w_wr_cnt_next;
          r_wr_err  <= resp_max(r_wr_err, w_wr_beat_resp);
          if (slv_w_wlast) begin
            // A short or long burst still lands its data; only the response records it.
            r_bresp    <= resp_max(resp_max(r_wr_err, w_wr_beat_resp), w_wr_len_resp);
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: if (slv_b_bready) r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset so it maps onto plain flops/RAM without a clear network.
  always_ff @(posedge clk_i) begin
    if (w_wr_mem_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (slv_w_wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= slv_w_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]                r_rd_state;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [AXI_ADDR_WIDTH-1:0] r_rd_addr;
  logic [7:0]                r_rd_len, r_rd_beat;
  logic [2:0]                r_rd_size;
  logic [1:0]                r_rd_burst;
  logic                      r_rvalid, r_rlast;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;

  logic                      w_ar_hs, w_r_hs, w_rd_oob;
  logic [AXI_ADDR_WIDTH-1:0] w_rd_load_addr;
  logic [2:0]                w_rd_load_size;
  logic [1:0]                w_rd_load_burst, w_rd_load_resp;
  logic [AXI_DATA_WIDTH-1:0] w_rd_load_data;

  assign slv_ar_arready = (r_rd_state == R_IDLE) && r_rdy_en;
  assign slv_r_rid      = r_rid;
  assign slv_r_rdata    = r_rdata;
  assign slv_r_rresp    = r_rresp;
  assign slv_r_rlast    = r_rlast;
  assign slv_r_rvalid   = r_rvalid;

  assign w_ar_hs = slv_ar_arvalid && slv_ar_arready;
  assign w_r_hs  = r_rvalid && slv_r_rready;

  // The beat being loaded is either the first beat of a new command or the successor of the current one.
  assign w_rd_load_addr  = (r_rd_state == R_IDLE) ? slv_ar_araddr
                                                  : next_addr(r_rd_addr, r_rd_size, r_rd_burst);
  assign w_rd_load_size  = (r_rd_state == R_IDLE) ? slv_ar_arsize  : r_rd_size;
  assign w_rd_load_burst = (r_rd_state == R_IDLE) ? slv_ar_arburst : r_rd_burst;
  assign w_rd_load_resp  = beat_resp(w_rd_oob, w_rd_load_size, w_rd_load_burst);
  assign w_rd_load_data  = (w_rd_load_resp == RESP_OKAY) ? r_mem[w_rd_load_addr[OFFS +: IDX_W]] : '0;

`ifdef AXI_SRAM_RESP_DECERR_EN
  assign w_wr_oob = (r_wr_addr >> (OFFS + IDX_W)) != '0;
  assign w_rd_oob = (w_rd_load_addr >> (OFFS + IDX_W)) != '0;
`else
  assign w_wr_oob = 1'b0;
  assign w_rd_oob = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= R_IDLE;
      r_rid      <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_beat  <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else if (r_rd_state == R_IDLE) begin
      if (w_ar_hs) begin
        r_rid      <= slv_ar_arid;
        r_rd_addr  <= w_rd_load_addr;
        r_rd_len   <= slv_ar_arlen;
        r_rd_size  <= slv_ar_arsize;
        r_rd_burst <= slv_ar_arburst;
        r_rd_beat  <= '0;
        r_rvalid   <= 1'b1;
        r_rlast    <= (slv_ar_arlen == 8'd0);
        r_rdata    <= w_rd_load_data;
        r_rresp    <= w_rd_load_resp;
        r_rd_state <= R_DATA;
      end
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rvalid   <= 1'b0;
        r_rlast    <= 1'b0;
        r_rd_state <= R_IDLE;
      end else begin
        r_rd_addr <= w_rd_load_addr;
        r_rd_beat <= r_rd_beat + 8'd1;
        r_rlast   <= (r_rd_beat + 8'd1 == r_rd_len);
        r_rdata   <= w_rd_load_data;
        r_rresp   <= w_rd_load_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized self-checking bench for axi_sram_responder against a byte-array memory model.
module tb_axi_sram_responder;

  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [10:0] aw_id, ar_id, b_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

  always #5 clk = ~clk;

  axi_sram_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .slv_aw_awid(aw_id), .slv_aw_awaddr(aw_addr), .slv_aw_awlen(aw_len),
    .slv_aw_awsize(aw_size), .slv_aw_awburst(aw_burst),
    .slv_aw_awvalid(aw_valid), .slv_aw_awready(aw_ready),
    .slv_w_wdata(w_data), .slv_w_wstrb(w_strb), .slv_w_wlast(w_last),
    .slv_w_wvalid(w_valid), .slv_w_wready(w_ready),
    .slv_b_bid(b_id), .slv_b_bresp(b_resp), .slv_b_bvalid(b_valid), .slv_b_bready(b_ready),
    .slv_ar_arid(ar_id), .slv_ar_araddr(ar_addr), .slv_ar_arlen(ar_len),
    .slv_ar_arsize(ar_size), .slv_ar_arburst(ar_burst),
    .slv_ar_arvalid(ar_valid), .slv_ar_arready(ar_ready),
    .slv_r_rid(r_id), .slv_r_rdata(r_data), .slv_r_rresp(r_resp), .slv_r_rlast(r_last),
    .slv_r_rvalid(r_valid), .slv_r_rready(r_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic expire(input string tag);
    check(tag, 64'd0, 64'd1);
    finish_run();
  endtask

  // Reference memory: one 64-bit word per index, plus per-beat stimulus buffers.
  logic [63:0] mem_m [MW];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  function automatic int unsigned m_word(input logic [63:0] addr);
    return int'((addr / 8) % MW);
  endfunction

  function automatic logic [1:0] m_resp(input logic [63:0] addr, input int size, input int burst);
    logic [1:0] r;
    r = 2'b00;
    if (size > 3 || burst >= 2) r = 2'b10;
`ifdef AXI_SRAM_RESP_DECERR_EN
    if (addr / 8 >= MW) r = 2'b11;
`endif
    return r;
  endfunction

  function automatic logic [63:0] m_next(input logic [63:0] addr, input int size, input int burst);
    logic [63:0] bytes;
    bytes = 64'd1 << size;
    if (burst == 0) return addr;
    return (addr / bytes) * bytes + bytes;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic do_write(input logic [10:0] id, input logic [63:0] addr, input int len,
                          input int size, input int burst, input int nbeats, input int gap);
    logic [63:0] a;
    logic [1:0]  exp_resp, br;
    int          t;
    a = addr;
    exp_resp = 2'b00;
    for (int i = 0; i < nbeats; i++) begin
      br = m_resp(a, size, burst);
      exp_resp = worst(exp_resp, br);
      if (br == 2'b00)
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) mem_m[m_word(a)][b*8 +: 8] = wd[i][b*8 +: 8];
      a = m_next(a, size, burst);
    end
    if (nbeats != len + 1) exp_resp = worst(exp_resp, 2'b10);

    aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst);
    aw_valid = 1'b1;
    w_valid = 1'b1; w_data = wd[0]; w_strb = ws[0]; w_last = (nbeats == 1);
    t = 0;
    while (!aw_ready) begin
      @(negedge clk);
      if (++t > 200) expire("aw_timeout");
    end
    check("aw_wready_exclusive", {63'd0, w_ready}, 64'd0);
    @(negedge clk);
    aw_valid = 1'b0;
    check("wready_after_aw", {63'd0, w_ready}, 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      if (gap > 0 && $urandom_range(0, 3) == 0) begin
        w_valid = 1'b0;
        repeat ($urandom_range(1, gap)) @(negedge clk);
      end
      w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == nbeats - 1);
      t = 0;
      while (!w_ready) begin
        @(negedge clk);
        if (++t > 200) expire("w_timeout");
      end
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("bvalid_after_wlast", {63'd0, b_valid}, 64'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    b_ready = 1'b1;
    check("bid", {53'd0, b_id}, {53'd0, id});
    check("bresp", {62'd0, b_resp}, {62'd0, exp_resp});
    @(negedge clk);
    b_ready = 1'b0;
    check("bvalid_drop", {63'd0, b_valid}, 64'd0);
    check("awready_after_b", {63'd0, aw_ready}, 64'd1);
  endtask

  // rmode: 0 = rready held high, 1 = random rready, 2 = repeating 1,0,0,1.
  task automatic do_read(input logic [10:0] id, input logic [63:0] addr, input int len,
                         input int size, input int burst, input int rmode);
    logic [63:0] ed [256];
    logic [1:0]  er [256];
    logic [63:0] a, sd;
    logic [1:0]  sr;
    logic        sl;
    bit          stalled;
    int          beat, cyc, t;
    int          pat [4] = '{1, 0, 0, 1};
    a = addr;
    for (int i = 0; i <= len; i++) begin
      er[i] = m_resp(a, size, burst);
      ed[i] = (er[i] == 2'b00) ? mem_m[m_word(a)] : 64'd0;
      a = m_next(a, size, burst);
    end
    ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst);
    ar_valid = 1'b1;
    t = 0;
    while (!ar_ready) begin
      @(negedge clk);
      if (++t > 200) expire("ar_timeout");
    end
    @(negedge clk);
    ar_valid = 1'b0;
    check("rvalid_after_ar", {63'd0, r_valid}, 64'd1);
    beat = 0; cyc = 0; stalled = 1'b0; sd = '0; sr = '0; sl = 1'b0;
    while (beat <= len) begin
      check("rvalid_hold", {63'd0, r_valid}, 64'd1);
      if (stalled) begin
        check("stall_rdata", r_data, sd);
        check("stall_rresp", {62'd0, r_resp}, {62'd0, sr});
        check("stall_rlast", {63'd0, r_last}, {63'd0, sl});
      end
      case (rmode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'($urandom_range(0, 1));
        default: r_ready = 1'(pat[cyc % 4]);
      endcase
      cyc++;
      if (r_valid && r_ready) begin
        if (size <= 3) check("rdata", r_data, ed[beat]);
        check("rresp", {62'd0, r_resp}, {62'd0, er[beat]});
        check("rlast", {63'd0, r_last}, {63'd0, beat == len});
        check("rid", {53'd0, r_id}, {53'd0, id});
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = r_valid;
        sd = r_data; sr = r_resp; sl = r_last;
      end
      if (cyc > 2000) expire("r_timeout");
      @(negedge clk);
    end
    r_ready = 1'b0;
    check("rvalid_drop", {63'd0, r_valid}, 64'd0);
    check("arready_after_rlast", {63'd0, ar_ready}, 64'd1);
  endtask

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'($urandom);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = 64'($urandom_range(0, MW * 8 - 1));
    if ($urandom_range(0, 7) == 0) a = a | (64'd1 << $urandom_range(13, 63));
    return a;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, size, burst, nb;
    logic [63:0] a;

    rst_i = 1'b1;
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_data = '0; w_strb = '0; w_last = 0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    repeat (3) @(negedge clk);
    check("rst_awready", {63'd0, aw_ready}, 64'd0);
    check("rst_arready", {63'd0, ar_ready}, 64'd0);
    check("rst_wready", {63'd0, w_ready}, 64'd0);
    check("rst_bvalid", {63'd0, b_valid}, 64'd0);
    check("rst_rvalid", {63'd0, r_valid}, 64'd0);
    check("rst_rlast", {63'd0, r_last}, 64'd0);
    check("rst_bresp", {62'd0, b_resp}, 64'd0);
    check("rst_rresp", {62'd0, r_resp}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_awready", {63'd0, aw_ready}, 64'd1);
    check("post_rst_arready", {63'd0, ar_ready}, 64'd1);

    // Fill the whole array so every later read has a defined reference.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(11'(k), 64'(k * 2048), 255, 3, 1, 256, 0);
    end

    // Basic 4-beat INCR write then read.
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    do_write(11'h05A, 64'h100, 3, 3, 1, 4, 0);
    do_read(11'h3C5, 64'h100, 3, 3, 1, 0);

    // Partial strobe over a zeroed word.
    wd[0] = 64'd0; ws[0] = 8'hFF;
    do_write(11'h1, 64'h400, 0, 3, 1, 1, 0);
    wd[0] = 64'hAABBCCDD_EEFF0011; ws[0] = 8'h0F;
    do_write(11'h2, 64'h400, 0, 3, 1, 1, 0);
    do_read(11'h3, 64'h400, 0, 3, 1, 0);
    check("partial_strobe_word", r_data, 64'h00000000_EEFF0011);

    // Stalled read with rready pattern 1,0,0,1.
    do_read(11'h7FF, 64'h100, 3, 3, 1, 2);

    // Early wlast: two beats of a len-3 burst.
    rand_beats(2);
    do_write(11'h44, 64'h200, 3, 3, 1, 2, 0);
    do_read(11'h45, 64'h200, 3, 3, 1, 0);

    // Address one past the array: DECERR or wrap to word 0.
    do_read(11'h66, 64'(MW * 8), 0, 3, 1, 0);

    // WRAP bursts are refused.
    rand_beats(4);
    do_write(11'h70, 64'h300, 3, 3, 2, 4, 0);
    do_read(11'h71, 64'h300, 3, 3, 2, 0);
    do_read(11'h72, 64'h300, 3, 3, 1, 1);

    // Oversized beats: error response, burst still consumed.
    for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'h00; end
    do_write(11'h80, 64'h500, 1, 4, 1, 2, 0);
    do_read(11'h81, 64'h500, 1, 4, 1, 0);

    // Reset during the second beat of a read.
    ar_id = 11'h9; ar_addr = 64'h100; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'd1;
    ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_beat2", r_data, mem_m[m_word(64'h108)]);
    rst_i = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", {63'd0, r_valid}, 64'd0);
    check("midrst_arready", {63'd0, ar_ready}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_arready_back", {63'd0, ar_ready}, 64'd1);
    do_read(11'hA, 64'h100, 3, 3, 1, 0);

    // Concurrent write and read on disjoint halves of the array.
    for (int it = 0; it < 10; it++) begin
      rand_beats(8);
      fork
        do_write(11'($urandom), 64'($urandom_range(0, 255) * 8), 7, 3, 1, 8, 2);
        do_read(11'($urandom), 64'(4096 + $urandom_range(0, 255) * 8), 7, 3, 1, 1);
      join
    end

    // Randomized mixed traffic.
    for (int it = 0; it < 80; it++) begin
      len = $urandom_range(0, 7);
      size = $urandom_range(0, 3);
      burst = ($urandom_range(0, 3) == 0) ? 0 : 1;
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        nb = len + 1;
        if ($urandom_range(0, 7) == 0) nb = (len == 0) ? 2 : len;
        rand_beats(nb);
        do_write(11'($urandom), a, len, size, burst, nb, 2);
      end else begin
        do_read(11'($urandom), a, len, size, burst, 1);
      end
    end

    finish_run();
  end

endmodule
